// File: rtl/mmcm_ps_arbiter.sv
// mmcm_ps_arbiter
// Round-robin arbiter that shares one MMCM phase-shift sequencer between
// pREQ requesters. Each requester owns a coalescing target register and a
// pending bit. One operation is outstanding at a time, and a watchdog
// aborts an operation whose sequencer never reports completion.
module mmcm_ps_arbiter #(
    parameter int unsigned pREQ     = 2,
    parameter int unsigned pTIMEOUT = 1024
) (
    input  logic                 clk_usb,
    input  logic                 reset,
    input  logic [16*pREQ-1:0]   I_req_step,
    input  logic [pREQ-1:0]      I_req_load,
    output logic [pREQ-1:0]      O_req_busy,
    output logic [pREQ-1:0]      O_req_done,
    output logic [15:0]          O_step_index,
    output logic                 O_load,
    input  logic                 I_done,
    output logic [1:0]           O_active_id,
    output logic                 O_timeout,
    input  logic                 I_clear_timeout
);

    localparam int unsigned IDW      = (pREQ > 1) ? $clog2(pREQ) : 1;
    localparam bit          WD_EN    = (pTIMEOUT != 0);
    localparam logic [15:0] WD_LIMIT = 16'(pTIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [pREQ-1:0]   pending;
    logic [15:0]       target [pREQ];
    logic [IDW-1:0]    last_grant;
    logic [15:0]       wd;

    logic              grant_found;
    logic [IDW-1:0]    grant_sel;
    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    act_sel;
    logic              grant_fire;
    logic              done_evt;
    logic              to_evt;
    logic              finish;
    logic [pREQ-1:0]   done_nxt;

    assign act_sel = O_active_id[IDW-1:0];

    // Per-requester target and pending registers; a new load beats a grant clear.
    for (genvar gi = 0; gi < pREQ; gi++) begin : g_req
        logic        pend_r;
        logic [15:0] tgt_r;

        // Capture the latest target and track whether it is still owed a grant.
        always_ff @(posedge clk_usb or posedge reset) begin
            if (reset) begin
                pend_r <= 1'b0;
                tgt_r  <= '0;
            end else begin
                if (I_req_load[gi]) begin
                    pend_r <= 1'b1;
                    tgt_r  <= I_req_step[16*gi +: 16];
                end else if (grant_fire && (grant_sel == IDW'(gi))) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign pending[gi] = pend_r;
        assign target[gi]  = tgt_r;
    end

    // Round-robin search: first pending index above last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= pREQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % pREQ);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: grant from IDLE, return on completion or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_found) state_nxt = ST_WAIT;
            ST_WAIT: if (finish)      state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: grant/finish events, next done vector and busy flags.
    always_comb begin
        grant_fire = (state == ST_IDLE) && grant_found;
        done_evt   = (state == ST_WAIT) && I_done;
        to_evt     = WD_EN && (state == ST_WAIT) && !I_done && (wd == WD_LIMIT);
        finish     = done_evt || to_evt;
        done_nxt   = finish ? (pREQ'(1'b1) << act_sel) : '0;
        O_req_busy = pending | ((state == ST_WAIT) ? (pREQ'(1'b1) << act_sel) : '0);
    end

    // Registered sequencer interface, done pulses, watchdog and sticky timeout.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            O_load       <= 1'b0;
            O_step_index <= '0;
            O_req_done   <= '0;
            O_active_id  <= '0;
            O_timeout    <= 1'b0;
            last_grant   <= IDW'(pREQ - 1);
            wd           <= '0;
        end else begin
            O_load     <= grant_fire;
            O_req_done <= done_nxt;
            if (grant_fire) begin
                O_step_index <= target[grant_sel];
                O_active_id  <= 2'(grant_sel);
                last_grant   <= grant_sel;
                wd           <= '0;
            end else if ((state == ST_WAIT) && !finish) begin
                wd <= wd + 16'd1;
            end
            if (to_evt) begin
                O_timeout <= 1'b1;
            end else if (I_clear_timeout) begin
                O_timeout <= 1'b0;
            end
        end
    end

endmodule
